// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hit path, single outstanding line refill.
// Optional hit/miss statistics counters are compiled in when ICACHE_STATS_EN is defined.
module icache_dm #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int NUM_SETS   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  icache_ready,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    output logic [LINE_WIDTH-1:0] rsp_data,
    output logic                  req_valid_miss,
    output logic [ADDR_WIDTH-1:0] req_addr_miss,
    input  logic [LINE_WIDTH-1:0] rsp_data_miss,
    input  logic                  rsp_valid_miss
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int OFF   = $clog2(LINE_WIDTH / 8);
    localparam int IDX   = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_WIDTH - OFF - IDX;

    typedef enum logic {
        ST_IDLE,
        ST_MISS_REQ
    } state_t;

    state_t                  r_state;
    logic                    r_ready;
    logic                    r_req_valid_miss;
    logic [ADDR_WIDTH-1:0]   r_req_addr_miss;
    logic [NUM_SETS-1:0]     r_valid;
    logic [TAG_W-1:0]        r_tag  [NUM_SETS];
    logic [LINE_WIDTH-1:0]   r_data [NUM_SETS];

    logic [IDX-1:0]          w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic [ADDR_WIDTH-1:0]   w_line_addr;
    logic [IDX-1:0]          w_fill_idx;
    logic [TAG_W-1:0]        w_fill_tag;
    logic                    w_lookup;
    logic                    w_match;
    logic                    w_hit;
    logic                    w_miss;
    logic                    w_fill;
    logic                    w_unused_off;

    assign w_idx        = req_addr[OFF+IDX-1:OFF];
    assign w_tag        = req_addr[ADDR_WIDTH-1:OFF+IDX];
    assign w_line_addr  = {req_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    assign w_unused_off = ^req_addr[OFF-1:0];

    // The latched refill address carries the victim set and its new tag.
    assign w_fill_idx   = r_req_addr_miss[OFF+IDX-1:OFF];
    assign w_fill_tag   = r_req_addr_miss[ADDR_WIDTH-1:OFF+IDX];

    // Reset masks every event in its cycle, including the combinational response.
    assign w_lookup = !reset && (r_state == ST_IDLE) && req_valid;
    assign w_match  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_hit    = w_lookup && w_match;
    assign w_miss   = w_lookup && !w_match;
    assign w_fill   = !reset && (r_state == ST_MISS_REQ) && rsp_valid_miss;

    assign rsp_valid = w_hit || w_fill;
    always_comb begin
        rsp_data = '0;
        if (w_hit) begin
            rsp_data = r_data[w_idx];
        end else if (w_fill) begin
            rsp_data = rsp_data_miss;
        end
    end

    assign icache_ready   = r_ready;
    assign req_valid_miss = r_req_valid_miss;
    assign req_addr_miss  = r_req_addr_miss;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_ready          <= 1'b1;
            r_req_valid_miss <= 1'b0;
            r_req_addr_miss  <= '0;
            r_valid          <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        r_state          <= ST_MISS_REQ;
                        r_ready          <= 1'b0;
                        r_req_valid_miss <= 1'b1;
                        r_req_addr_miss  <= w_line_addr;
                    end
                end
                ST_MISS_REQ: begin
                    if (rsp_valid_miss) begin
                        r_state              <= ST_IDLE;
                        r_ready              <= 1'b1;
                        r_req_valid_miss     <= 1'b0;
                        r_valid[w_fill_idx]  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clock) begin
        if (w_fill) begin
            r_data[w_fill_idx] <= rsp_data_miss;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss/refill, hits, eviction, ignored requests and reset mid-miss.
module tb_icache_dm;

    logic         clock;
    logic         reset;
    logic         icache_ready;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         req_valid_miss;
    logic [31:0]  req_addr_miss;
    logic [127:0] rsp_data_miss;
    logic         rsp_valid_miss;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [127:0] D1 = 128'h4444_3333_2222_1111;
    localparam logic [127:0] D2 = 128'hdead_beef_0bad_f00d_8888_7777_6666_5555;
    localparam logic [127:0] DX = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;

    icache_dm dut (
        .clock          (clock),
        .reset          (reset),
        .icache_ready   (icache_ready),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .req_valid_miss (req_valid_miss),
        .req_addr_miss  (req_addr_miss),
        .rsp_data_miss  (rsp_data_miss),
        .rsp_valid_miss (rsp_valid_miss)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge so inputs change and outputs are sampled away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        req_valid      = 1'b0;
        req_addr       = '0;
        rsp_valid_miss = 1'b0;
        rsp_data_miss  = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_ready",      {127'd0, icache_ready},   128'd1);
        chk("rst_rsp_valid",  {127'd0, rsp_valid},      128'd0);
        chk("rst_rsp_data",   rsp_data,                 128'd0);
        chk("rst_miss_valid", {127'd0, req_valid_miss}, 128'd0);
        chk("rst_miss_addr",  {96'd0, req_addr_miss},   128'd0);

        // Cold miss on 0x1000
        tick();
        req_valid = 1'b1;
        req_addr  = 32'h0000_1000;
        #1;
        chk("cold_no_rsp",    {127'd0, rsp_valid},      128'd0);
        chk("cold_ready",     {127'd0, icache_ready},   128'd1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("m1_miss_valid",  {127'd0, req_valid_miss}, 128'd1);
        chk("m1_miss_addr",   {96'd0, req_addr_miss},   {96'd0, 32'h0000_1000});
        chk("m1_ready",       {127'd0, icache_ready},   128'd0);
        tick();
        chk("m1_hold_valid",  {127'd0, req_valid_miss}, 128'd1);
        chk("m1_hold_rsp",    {127'd0, rsp_valid},      128'd0);
        rsp_valid_miss = 1'b1;
        rsp_data_miss  = D1;
        #1;
        chk("m1_bypass_vld",  {127'd0, rsp_valid},      128'd1);
        chk("m1_bypass_data", rsp_data,                 D1);
        tick();
        rsp_valid_miss = 1'b0;
        rsp_data_miss  = '0;
        #1;
        chk("m1_done_ready",  {127'd0, icache_ready},   128'd1);
        chk("m1_done_miss",   {127'd0, req_valid_miss}, 128'd0);
        chk("m1_done_rsp",    {127'd0, rsp_valid},      128'd0);
        chk("m1_done_data",   rsp_data,                 128'd0);

        // Hit on the same line at another offset
        req_valid = 1'b1;
        req_addr  = 32'h0000_1008;
        #1;
        chk("hit_vld",        {127'd0, rsp_valid},      128'd1);
        chk("hit_data",       rsp_data,                 D1);
        chk("hit_no_miss",    {127'd0, req_valid_miss}, 128'd0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("hit_after_miss", {127'd0, req_valid_miss}, 128'd0);
        chk("hit_after_rdy",  {127'd0, icache_ready},   128'd1);

        // Refill data arriving while idle must not touch the array
        rsp_valid_miss = 1'b1;
        rsp_data_miss  = DX;
        #1;
        chk("idle_fill_rsp",  {127'd0, rsp_valid},      128'd0);
        tick();
        rsp_valid_miss = 1'b0;
        rsp_data_miss  = '0;
        req_valid      = 1'b1;
        req_addr       = 32'h0000_1000;
        #1;
        chk("idle_fill_hit",  {127'd0, rsp_valid},      128'd1);
        chk("idle_fill_data", rsp_data,                 D1);
        tick();

        // Conflict miss: 0x1080 maps to set 0 with a different tag
        req_addr = 32'h0000_1080;
        #1;
        chk("evict_no_rsp",   {127'd0, rsp_valid},      128'd0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("evict_addr",     {96'd0, req_addr_miss},   {96'd0, 32'h0000_1080});
        // Request during MISS_REQ is ignored
        req_valid = 1'b1;
        req_addr  = 32'h0000_2000;
        #1;
        chk("busy_no_rsp",    {127'd0, rsp_valid},      128'd0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("busy_addr_same", {96'd0, req_addr_miss},   {96'd0, 32'h0000_1080});
        chk("busy_ready",     {127'd0, icache_ready},   128'd0);
        chk("busy_miss_vld",  {127'd0, req_valid_miss}, 128'd1);
        rsp_valid_miss = 1'b1;
        rsp_data_miss  = D2;
        #1;
        chk("evict_bypass",   rsp_data,                 D2);
        tick();
        rsp_valid_miss = 1'b0;
        rsp_data_miss  = '0;
        req_valid      = 1'b1;
        req_addr       = 32'h0000_1084;
        #1;
        chk("evict_hit_vld",  {127'd0, rsp_valid},      128'd1);
        chk("evict_hit_data", rsp_data,                 D2);
        tick();
        req_addr = 32'h0000_1000;
        #1;
        chk("old_tag_miss",   {127'd0, rsp_valid},      128'd0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("old_tag_addr",   {96'd0, req_addr_miss},   {96'd0, 32'h0000_1000});
`ifdef ICACHE_STATS_EN
        chk("stat_hits",      {96'd0, hit_count},       128'd3);
        chk("stat_misses",    {96'd0, miss_count},      128'd3);
`endif

        // Reset while refill outstanding, with a coincident refill beat
        reset          = 1'b1;
        rsp_valid_miss = 1'b1;
        rsp_data_miss  = DX;
        #1;
        chk("rst_fill_rsp",   {127'd0, rsp_valid},      128'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_ready",  {127'd0, icache_ready},   128'd1);
        chk("rst_mid_miss",   {127'd0, req_valid_miss}, 128'd0);
        chk("late_fill_rsp",  {127'd0, rsp_valid},      128'd0);
        tick();
        rsp_valid_miss = 1'b0;
        rsp_data_miss  = '0;
        req_valid      = 1'b1;
        req_addr       = 32'h0000_1000;
        #1;
        chk("post_rst_miss",  {127'd0, rsp_valid},      128'd0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("post_rst_req",   {127'd0, req_valid_miss}, 128'd1);
        chk("post_rst_addr",  {96'd0, req_addr_miss},   {96'd0, 32'h0000_1000});
`ifdef ICACHE_STATS_EN
        chk("stat_hits_rst",  {96'd0, hit_count},       128'd0);
        chk("stat_miss_rst",  {96'd0, miss_count},      128'd1);
`endif
        rsp_valid_miss = 1'b1;
        rsp_data_miss  = D1;
        #1;
        chk("final_fill",     rsp_data,                 D1);
        tick();
        rsp_valid_miss = 1'b0;
        #1;
        chk("final_ready",    {127'd0, icache_ready},   128'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
